// File: rtl/scope_pkg.sv
// Shared definitions for the capture path: front-panel mode codes, capture FSM
// state encoding and the per-mode decimation ratios.
package scope_pkg;

  localparam logic [1:0] MODE_STOP = 2'b00;
  localparam logic [1:0] MODE_X1   = 2'b01;
  localparam logic [1:0] MODE_X4   = 2'b10;
  localparam logic [1:0] MODE_X16  = 2'b11;

  localparam int RATIO_X1  = 1;
  localparam int RATIO_X4  = 4;
  localparam int RATIO_X16 = 16;

  // Wide enough to hold RATIO_X16-1.
  localparam int DEC_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Terminal decimation count (R-1) for a mode code; stop maps to 0.
  function automatic logic [DEC_W-1:0] dec_last(input logic [1:0] m);
    case (m)
      MODE_X1:  dec_last = DEC_W'(RATIO_X1 - 1);
      MODE_X4:  dec_last = DEC_W'(RATIO_X4 - 1);
      MODE_X16: dec_last = DEC_W'(RATIO_X16 - 1);
      default:  dec_last = '0;
    endcase
  endfunction

endpackage

// File: rtl/tick_decimator.sv
// Divides the ADC strobe stream by 1/4/16 per mode; tick is combinational off the
// current strobe (zero latency), no backpressure. clear restarts the count and suppresses tick.
module tick_decimator
  import scope_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       adc_valid,
  input  logic       clear,
  output logic       tick
);

  logic [DEC_W-1:0] dec_cnt;
  logic [DEC_W-1:0] last;

  assign last = dec_last(mode);
  assign tick = adc_valid && !clear && (mode != MODE_STOP) && (dec_cnt == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= '0;
    end else if (clear || mode == MODE_STOP) begin
      dec_cnt <= '0;
    end else if (adc_valid) begin
      dec_cnt <= (dec_cnt == last) ? '0 : dec_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Decimated, edge-triggered single-frame capture into the frame buffer with auto-trigger fallback.
// Write port has one cycle latency from the tick; the frame is held until the display acks it.
module capture_ctrl
  import scope_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 9,
  parameter int AUTO_TICKS = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic                  adc_valid,
  input  logic [DATA_W-1:0]     adc_data,
  input  logic [DATA_W-1:0]     trig_level,
  output logic                  wr_en,
  output logic [DEPTH_LOG2-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  frame_ready,
  input  logic                  frame_ack,
  output logic                  auto_trig,
  output logic                  busy
);

  localparam int TMO_W = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(AUTO_TICKS - 1);
  localparam logic [DEPTH_LOG2-1:0] ADDR_LAST = '1;

  state_t                  state, state_nxt;
  logic [1:0]              mode_q;
  logic                    mode_chg, abort, dec_clr, tick, hit;
  logic [DATA_W-1:0]       prev, prev_nxt;
  logic                    prev_valid, prev_valid_nxt;
  logic [TMO_W-1:0]        tmo_cnt, tmo_nxt;
  logic [DEPTH_LOG2-1:0]   addr_cnt, addr_nxt;
  logic                    wr_en_nxt;
  logic [DEPTH_LOG2-1:0]   wr_addr_nxt;
  logic [DATA_W-1:0]       wr_data_nxt;
  logic                    auto_nxt;

  assign mode_chg    = (mode != mode_q);
  assign busy        = (state == ST_ARM) || (state == ST_WAIT_TRIG) || (state == ST_CAPTURE);
  assign frame_ready = (state == ST_DONE);
  assign abort       = mode_chg && busy;
  // Holding the decimator clear outside the active states makes every arm start on a fresh count.
  assign dec_clr     = abort || (state == ST_IDLE) || (state == ST_DONE);
  assign hit         = prev_valid && (prev < trig_level) && (adc_data >= trig_level);

  tick_decimator u_dec (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .adc_valid (adc_valid),
    .clear     (dec_clr),
    .tick      (tick)
  );

  always_comb begin
    state_nxt      = state;
    prev_nxt       = prev;
    prev_valid_nxt = prev_valid;
    tmo_nxt        = tmo_cnt;
    addr_nxt       = addr_cnt;
    wr_en_nxt      = 1'b0;
    wr_addr_nxt    = wr_addr;
    wr_data_nxt    = wr_data;
    auto_nxt       = auto_trig;

    if (abort) begin
      state_nxt      = (mode == MODE_STOP) ? ST_IDLE : ST_ARM;
      prev_valid_nxt = 1'b0;
      tmo_nxt        = '0;
      addr_nxt       = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mode != MODE_STOP) state_nxt = ST_ARM;
        end
        ST_ARM: begin
          if (tick) begin
            prev_nxt       = adc_data;
            prev_valid_nxt = 1'b1;
            state_nxt      = ST_WAIT_TRIG;
          end
        end
        ST_WAIT_TRIG: begin
          if (tick) begin
            prev_nxt = adc_data;
            if (hit || tmo_cnt == TMO_LAST) begin
              wr_en_nxt   = 1'b1;
              wr_addr_nxt = '0;
              wr_data_nxt = adc_data;
              auto_nxt    = !hit;
              tmo_nxt     = '0;
              addr_nxt    = DEPTH_LOG2'(1);
              state_nxt   = ST_CAPTURE;
            end else begin
              tmo_nxt = tmo_cnt + 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          if (tick) begin
            prev_nxt    = adc_data;
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = addr_cnt;
            wr_data_nxt = adc_data;
            if (addr_cnt == ADDR_LAST) begin
              addr_nxt  = '0;
              state_nxt = ST_DONE;
            end else begin
              addr_nxt = addr_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (frame_ack) begin
            prev_valid_nxt = 1'b0;
            state_nxt      = (mode == MODE_STOP) ? ST_IDLE : ST_ARM;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_STOP;
      prev       <= '0;
      prev_valid <= 1'b0;
      tmo_cnt    <= '0;
      addr_cnt   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      auto_trig  <= 1'b0;
    end else begin
      mode_q     <= mode;
      prev       <= prev_nxt;
      prev_valid <= prev_valid_nxt;
      tmo_cnt    <= tmo_nxt;
      addr_cnt   <= addr_nxt;
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
      auto_trig  <= auto_nxt;
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: stop, normal trigger, decimation, abort, handshake,
// auto trigger and asynchronous reset, each against hand-derived expectations.
module tb_capture_ctrl;

  localparam int DATA_W     = 8;
  localparam int DEPTH_LOG2 = 9;
  localparam int AUTO_TICKS = 1024;
  localparam int FRAME      = 512;

  logic                  clk;
  logic                  rst_n;
  logic [1:0]            mode;
  logic                  adc_valid;
  logic [DATA_W-1:0]     adc_data;
  logic [DATA_W-1:0]     trig_level;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  frame_ready;
  logic                  frame_ack;
  logic                  auto_trig;
  logic                  busy;

  int n_vec  = 0;
  int n_miss = 0;

  capture_ctrl #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .AUTO_TICKS (AUTO_TICKS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .adc_valid   (adc_valid),
    .adc_data    (adc_data),
    .trig_level  (trig_level),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_ready (frame_ready),
    .frame_ack   (frame_ack),
    .auto_trig   (auto_trig),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, settle 1 time unit; frame_ack is a single-cycle pulse.
  task automatic cyc(input logic v, input logic [DATA_W-1:0] d);
    adc_valid = v;
    adc_data  = d;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
    adc_valid = 1'b0;
  endtask

  initial begin
    int nwr, bad, first_s, last_s, wr_cnt, busy_cnt;
    logic [7:0] last_d, d0;
    logic ready_seen;

    rst_n = 1'b0; mode = 2'b00; adc_valid = 1'b0; adc_data = '0;
    trig_level = '0; frame_ack = 1'b0;

    // ---- reset and stop ----
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {wr_en, wr_addr, wr_data, frame_ready, auto_trig, busy}, 32'h0);
    rst_n = 1'b1;
    wr_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      cyc(1'b1, 8'($urandom_range(0, 255)));
      if (wr_en) wr_cnt++;
      if (busy || frame_ready) busy_cnt++;
    end
    chk("stop_no_writes", wr_cnt, 0);
    chk("stop_not_busy", busy_cnt, 0);

    // ---- normal trigger, mode x1, ramp 0x70 step 8 ----
    mode = 2'b01; trig_level = 8'h80;
    cyc(1'b0, 8'h00);
    chk("idle_to_arm_busy", busy, 1);
    nwr = 0; bad = 0; first_s = -1;
    for (int s = 0; s < 530; s++) begin
      cyc(1'b1, 8'(8'h70 + 8 * s));
      if (wr_en) begin
        if (first_s < 0) begin
          first_s = s;
          chk("trig_first_addr", wr_addr, 0);
          chk("trig_first_data", wr_data, 8'h80);
        end
        if (wr_addr !== 9'(nwr) || wr_data !== 8'(8'h80 + 8 * nwr)) bad++;
        nwr++;
      end
    end
    chk("trig_strobe_index", first_s, 2);
    chk("trig_write_count", nwr, FRAME);
    chk("trig_bad_writes", bad, 0);
    chk("trig_frame_ready", frame_ready, 1);
    chk("trig_auto_trig", auto_trig, 0);
    chk("trig_done_not_busy", busy, 0);

    // ---- ack in DONE clears frame_ready on that edge and re-arms ----
    frame_ack = 1'b1;
    cyc(1'b0, 8'h00);
    chk("ack_ready_low", frame_ready, 0);
    chk("ack_rearm_busy", busy, 1);

    // ---- decimation /16: ticks on strobes 15,31,47 -> trigger on 0x2F ----
    mode = 2'b11; trig_level = 8'h28;
    cyc(1'b0, 8'h00);
    nwr = 0; bad = 0; first_s = -1; last_s = 0; last_d = '0; d0 = '0;
    for (int s = 0; s < 420; s++) begin
      cyc(1'b1, 8'(s));
      if (wr_en) begin
        if (nwr == 0) begin
          first_s = s; d0 = wr_data;
        end else if (s - last_s != 16 || wr_data !== 8'(last_d + 8'd16) || wr_addr !== 9'(nwr)) begin
          bad++;
        end
        last_s = s; last_d = wr_data; nwr++;
        if (nwr == 20) break;
      end
    end
    chk("dec16_first_strobe", first_s, 47);
    chk("dec16_first_data", d0, 8'h2F);
    chk("dec16_write_count", nwr, 20);
    chk("dec16_spacing", bad, 0);

    // ---- mode change mid-capture at write 100 ----
    mode = 2'b01; trig_level = 8'h80;
    cyc(1'b0, 8'h00);
    nwr = 0;
    for (int s = 0; s < 200; s++) begin
      cyc(1'b1, 8'(8'h70 + 8 * s));
      if (wr_en) nwr++;
      if (nwr == 100) break;
    end
    chk("abort_pre_writes", nwr, 100);
    mode = 2'b10;
    cyc(1'b1, 8'hAA);
    chk("abort_drops_write", wr_en, 0);
    chk("abort_busy", busy, 1);
    // ratio 4 from a cleared count: ticks at k=3,7,..; 0x7C -> 0x8C crosses at k=19
    nwr = 0; bad = 0; first_s = -1; ready_seen = 1'b0;
    for (int k = 0; k < 19 + 4 * FRAME + 20; k++) begin
      frame_ack = (k == 25);
      cyc(1'b1, 8'(8'h40 + 4 * k));
      if (nwr == 0 && frame_ready) ready_seen = 1'b1;
      if (k == 25) chk("ack_in_capture_ignored", {frame_ready, busy}, 2'b01);
      if (wr_en) begin
        if (nwr == 0) first_s = k;
        if (k != 19 + 4 * nwr || wr_addr !== 9'(nwr) || wr_data !== 8'(8'h8C + 16 * nwr)) bad++;
        nwr++;
      end
      if (frame_ready) break;
    end
    chk("abort_no_ready", ready_seen, 0);
    chk("restart_first_strobe", first_s, 19);
    chk("restart_write_count", nwr, FRAME);
    chk("restart_bad_writes", bad, 0);
    chk("restart_frame_ready", frame_ready, 1);

    // ---- ack in DONE, next trigger lands at addr 0 ----
    frame_ack = 1'b1;
    cyc(1'b0, 8'h00);
    chk("ack2_ready_low", frame_ready, 0);
    first_s = -1;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, 8'(8'h40 + 4 * k));
      if (wr_en) begin
        first_s = k;
        chk("rearm_first_addr", wr_addr, 0);
        chk("rearm_first_data", wr_data, 8'h8C);
        break;
      end
    end
    chk("rearm_first_strobe", first_s, 19);

    // ---- auto trigger: 1 ARM tick + 1024 waiting ticks ----
    mode = 2'b01; trig_level = 8'hFF;
    cyc(1'b0, 8'h00);
    nwr = 0; bad = 0; first_s = -1;
    for (int k = 0; k < 1 + AUTO_TICKS + FRAME + 10; k++) begin
      cyc(1'b1, 8'h10);
      if (k == AUTO_TICKS - 1) chk("auto_not_yet", {wr_en, auto_trig}, 2'b00);
      if (wr_en) begin
        if (nwr == 0) begin
          first_s = k;
          chk("auto_flag_set", auto_trig, 1);
        end
        if (wr_addr !== 9'(nwr) || wr_data !== 8'h10) bad++;
        nwr++;
      end
    end
    chk("auto_first_strobe", first_s, AUTO_TICKS);
    chk("auto_write_count", nwr, FRAME);
    chk("auto_bad_writes", bad, 0);
    chk("auto_frame_ready", frame_ready, 1);
    chk("auto_flag_held", auto_trig, 1);

    // ---- asynchronous reset at write 300 ----
    frame_ack = 1'b1;
    cyc(1'b0, 8'h00);
    trig_level = 8'h80;
    nwr = 0;
    for (int s = 0; s < 400; s++) begin
      cyc(1'b1, 8'(8'h70 + 8 * s));
      if (wr_en) nwr++;
      if (wr_en && wr_addr == 9'd299) break;
    end
    chk("arst_pre_writes", nwr, 300);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_immediate", {wr_en, wr_addr, frame_ready, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mode = 2'b00;
    cyc(1'b0, 8'h00);
    chk("arst_stays_idle", {frame_ready, busy, wr_en}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
